// File: rtl/conv_pkg.sv
// Shared definitions for the convolver window shift register:
// default sizes, window-length clamping and flat-bus slice helpers.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 3;
    localparam int DEFAULT_LANES      = 1;

    // Effective window length: 0 means a window of one, and anything
    // beyond the physical chain collapses to the full chain.
    function automatic int clamp_len(input int cfg, input int depth);
        if (cfg < 1) begin
            return 1;
        end
        if (cfg > depth) begin
            return depth;
        end
        return cfg;
    endfunction

    // LSB of lane l inside a LANES*DATA_WIDTH bus.
    function automatic int lane_base(input int lane, input int data_width);
        return lane * data_width;
    endfunction

    // LSB of lane l, position i inside a LANES*DEPTH*DATA_WIDTH bus.
    function automatic int pos_base(input int lane, input int pos,
                                    input int depth, input int data_width);
        return (lane * depth + pos) * data_width;
    endfunction

endpackage

// File: rtl/window_shift_register_if.sv
// Handshake / data bundle for window_shift_register.
// The flush signal exists only when SHIFT_REG_FLUSH_EN is defined.
// master = environment (producer + consumer), slave = the shift register.
interface window_shift_register_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int LANES      = 1,
    parameter int LEN_W      = $clog2(DEPTH + 1)
);
    logic [LEN_W-1:0]                  cfg_length;
    logic                              in_valid;
    logic                              in_ready;
    logic [LANES*DATA_WIDTH-1:0]       shift_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES*DEPTH*DATA_WIDTH-1:0] data_out;
    logic                              evict_valid;
    logic [LANES*DATA_WIDTH-1:0]       evict_data;
    logic [LEN_W-1:0]                  fill_count;
`ifdef SHIFT_REG_FLUSH_EN
    logic                              flush;

    modport master (
        output cfg_length, in_valid, shift_in, out_ready, flush,
        input  in_ready, out_valid, data_out, evict_valid, evict_data, fill_count
    );

    modport slave (
        input  cfg_length, in_valid, shift_in, out_ready, flush,
        output in_ready, out_valid, data_out, evict_valid, evict_data, fill_count
    );
`else
    modport master (
        output cfg_length, in_valid, shift_in, out_ready,
        input  in_ready, out_valid, data_out, evict_valid, evict_data, fill_count
    );

    modport slave (
        input  cfg_length, in_valid, shift_in, out_ready,
        output in_ready, out_valid, data_out, evict_valid, evict_data, fill_count
    );
`endif
endinterface

// File: rtl/shift_lane.sv
// One lane of the window: a DEPTH x DATA_WIDTH register chain that shifts
// on shift_en (pos 0 = newest) and exposes the element at pos tap_len-1.
module shift_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        shift_en,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic [LEN_W-1:0]            tap_len,
    output logic [DEPTH*DATA_WIDTH-1:0] taps,
    output logic [DATA_WIDTH-1:0]       tap
);

    logic [DATA_WIDTH-1:0] data [DEPTH];

    // Register chain: clear wins over shift; the whole physical chain moves.
    // NOTE: the chain is reset explicitly -- the window contents are visible
    // on data_out, so they must come out of reset as zero, not X.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (shift_en) begin
            // NOTE: non-blocking assignments let every stage read its
            // neighbour's pre-edge value regardless of loop order.
            data[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    // Flatten the chain onto the lane's slice of data_out.
    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        assign taps[i*DATA_WIDTH +: DATA_WIDTH] = data[i];
    end

    // Eviction tap: element at pos tap_len-1 (tap_len is always 1..DEPTH).
    always_comb begin
        // NOTE: default first so every path assigns tap and no latch forms.
        tap = data[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (int'(tap_len) == i + 1) begin
                tap = data[i];
            end
        end
    end

endmodule

// File: rtl/window_shift_register.sv
// Multi-lane, variable-length window shift register with valid/ready
// handshake. Owns the handshake, fill counter, length latch and eviction
// register; each lane's data chain lives in shift_lane.
// Optional feature: define SHIFT_REG_FLUSH_EN to add the synchronous flush.
module window_shift_register
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int LANES      = DEFAULT_LANES
) (
    input logic                    clock,
    input logic                    reset_n,
    window_shift_register_if.slave bus
);

    localparam int LEN_W = $clog2(DEPTH + 1);

    logic [LEN_W-1:0]                  eff_len;
    logic [LEN_W-1:0]                  len_q;
    logic [LEN_W-1:0]                  fill_count_q;
    logic                              full;
    logic                              shift;
    logic                              len_change;
    logic                              flush_req;
    logic                              in_ready_int;
    logic                              evict_valid_q;
    logic [LANES*DATA_WIDTH-1:0]       evict_data_q;
    logic [LANES*DATA_WIDTH-1:0]       tap_bus;
    logic [LANES*DEPTH*DATA_WIDTH-1:0] data_bus;

`ifdef SHIFT_REG_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    // Window geometry and handshake. A full window blocks new input until
    // the consumer takes it; flush blocks input outright.
    assign eff_len      = LEN_W'(clamp_len(int'(bus.cfg_length), DEPTH));
    assign full         = (fill_count_q == eff_len);
    assign len_change   = (len_q != eff_len);
    assign in_ready_int = !flush_req && (!full || bus.out_ready);
    assign shift        = bus.in_valid && in_ready_int;

    // Per-lane data chains, all shifting in lockstep.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        shift_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .LEN_W      (LEN_W)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .shift_en (shift),
            .clear    (flush_req),
            .din      (bus.shift_in[lane_base(l, DATA_WIDTH) +: DATA_WIDTH]),
            .tap_len  (eff_len),
            .taps     (data_bus[pos_base(l, 0, DEPTH, DATA_WIDTH) +: DEPTH*DATA_WIDTH]),
            .tap      (tap_bus[lane_base(l, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Fill counter, length latch and eviction register.
    // A length change restarts filling but keeps the data; a shift while full
    // slides the window and captures the element falling off its end.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q         <= '0;
            fill_count_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
        end else begin
            len_q         <= eff_len;
            evict_valid_q <= 1'b0;
            if (flush_req || len_change) begin
                fill_count_q <= '0;
            end else if (shift && !full) begin
                fill_count_q <= fill_count_q + LEN_W'(1);
            end
            if (shift && full) begin
                evict_valid_q <= 1'b1;
                evict_data_q  <= tap_bus;
            end
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = full;
    assign bus.data_out    = data_bus;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_data  = evict_data_q;
    assign bus.fill_count  = fill_count_q;

endmodule

// File: tb/tb_window_shift_register.sv
// Directed bench for window_shift_register: DEPTH=3/LANES=2 main instance
// plus a DEPTH=5/LANES=1 instance for clamping an oversize cfg_length.
// Flush scenario is compiled only with SHIFT_REG_FLUSH_EN.
module tb_window_shift_register;

    localparam int DW = 32;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    window_shift_register_if #(.DATA_WIDTH(DW), .DEPTH(3), .LANES(2)) bus ();
    window_shift_register_if #(.DATA_WIDTH(DW), .DEPTH(5), .LANES(1)) bus5 ();

    window_shift_register #(.DATA_WIDTH(DW), .DEPTH(3), .LANES(2)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    window_shift_register #(.DATA_WIDTH(DW), .DEPTH(5), .LANES(1)) u_dut5 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus5.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected window: lane0 = a0..a2 (pos0 newest), lane1 = same + 0x100.
    function automatic logic [6*DW-1:0] exp_win(input logic [DW-1:0] a0,
                                                input logic [DW-1:0] a1,
                                                input logic [DW-1:0] a2);
        return {a2 + 32'h100, a1 + 32'h100, a0 + 32'h100, a2, a1, a0};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One handshake attempt on the main instance; lane1 carries v + 0x100.
    task automatic push(input logic [DW-1:0] v);
        bus.in_valid = 1'b1;
        bus.shift_in = {v + 32'h100, v};
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(2);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.fill_count !== 2'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", bus.fill_count); end
        checks++; if (bus.evict_valid !== 1'b0) begin errors++; $display("FAIL reset_evict_valid: got %b want 0", bus.evict_valid); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        checks++; if (bus.evict_data !== '0) begin errors++; $display("FAIL reset_evict_data: got %h want 0", bus.evict_data); end
        reset_n = 1'b1;
        idle(1);  // first edge after reset loads the length latch
    endtask

    task automatic test_fill();
        push(32'h11);
        checks++; if (bus.fill_count !== 2'd1) begin errors++; $display("FAIL fill_one: got %0d want 1", bus.fill_count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_one_valid: got %b want 0", bus.out_valid); end
        push(32'h22);
        push(32'h33);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_full_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.fill_count !== 2'd3) begin errors++; $display("FAIL fill_full_count: got %0d want 3", bus.fill_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.data_out !== exp_win(32'h33, 32'h22, 32'h11)) begin errors++; $display("FAIL fill_data: got %h want %h", bus.data_out, exp_win(32'h33, 32'h22, 32'h11)); end
        // Back-pressure: full with out_ready=0 must not accept.
        push(32'h99);
        checks++; if (bus.data_out !== exp_win(32'h33, 32'h22, 32'h11)) begin errors++; $display("FAIL stall_data: got %h want %h", bus.data_out, exp_win(32'h33, 32'h22, 32'h11)); end
        checks++; if (bus.evict_valid !== 1'b0) begin errors++; $display("FAIL stall_evict: got %b want 0", bus.evict_valid); end
    endtask

    task automatic test_evict();
        bus.out_ready = 1'b1;
        push(32'h44);
        bus.out_ready = 1'b0;
        checks++; if (bus.evict_valid !== 1'b1) begin errors++; $display("FAIL evict_pulse: got %b want 1", bus.evict_valid); end
        checks++; if (bus.evict_data !== {32'h111, 32'h11}) begin errors++; $display("FAIL evict_data: got %h want %h", bus.evict_data, {32'h111, 32'h11}); end
        checks++; if (bus.data_out !== exp_win(32'h44, 32'h33, 32'h22)) begin errors++; $display("FAIL evict_window: got %h want %h", bus.data_out, exp_win(32'h44, 32'h33, 32'h22)); end
        checks++; if (bus.fill_count !== 2'd3) begin errors++; $display("FAIL evict_fill: got %0d want 3", bus.fill_count); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL evict_out_valid: got %b want 1", bus.out_valid); end
        idle(1);
        checks++; if (bus.evict_valid !== 1'b0) begin errors++; $display("FAIL evict_one_cycle: got %b want 0", bus.evict_valid); end
        checks++; if (bus.evict_data !== {32'h111, 32'h11}) begin errors++; $display("FAIL evict_hold: got %h want %h", bus.evict_data, {32'h111, 32'h11}); end
    endtask

    task automatic test_len_change();
        // Length change together with a shift: data moves, fill forced to 0.
        bus.cfg_length = 2'd2;
        push(32'h55);
        checks++; if (bus.fill_count !== 2'd0) begin errors++; $display("FAIL lenchg_fill: got %0d want 0", bus.fill_count); end
        checks++; if (bus.evict_valid !== 1'b0) begin errors++; $display("FAIL lenchg_evict: got %b want 0", bus.evict_valid); end
        checks++; if (bus.data_out !== exp_win(32'h55, 32'h44, 32'h33)) begin errors++; $display("FAIL lenchg_shift: got %h want %h", bus.data_out, exp_win(32'h55, 32'h44, 32'h33)); end
        push(32'h66);
        push(32'h77);
        checks++; if (bus.out_valid !== 1'b1 || bus.fill_count !== 2'd2) begin errors++; $display("FAIL len2_full: got valid=%b fill=%0d want valid=1 fill=2", bus.out_valid, bus.fill_count); end
        // Grow back to 3 while full at length 2.
        bus.cfg_length = 2'd3;
        idle(1);
        checks++; if (bus.out_valid !== 1'b0 || bus.fill_count !== 2'd0) begin errors++; $display("FAIL len3_restart: got valid=%b fill=%0d want valid=0 fill=0", bus.out_valid, bus.fill_count); end
        checks++; if (bus.data_out !== exp_win(32'h77, 32'h66, 32'h55)) begin errors++; $display("FAIL len3_data_kept: got %h want %h", bus.data_out, exp_win(32'h77, 32'h66, 32'h55)); end
        push(32'h88);
        push(32'h99);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL len3_two_pushes: got %b want 0", bus.out_valid); end
        push(32'hAA);
        checks++; if (bus.out_valid !== 1'b1 || bus.fill_count !== 2'd3) begin errors++; $display("FAIL len3_refill: got valid=%b fill=%0d want valid=1 fill=3", bus.out_valid, bus.fill_count); end
        checks++; if (bus.data_out !== exp_win(32'hAA, 32'h99, 32'h88)) begin errors++; $display("FAIL len3_data: got %h want %h", bus.data_out, exp_win(32'hAA, 32'h99, 32'h88)); end
    endtask

    task automatic test_len_clamp();
        // cfg_length=0 behaves as a window of one.
        bus.cfg_length = 2'd0;
        idle(1);
        checks++; if (bus.fill_count !== 2'd0) begin errors++; $display("FAIL len0_restart: got %0d want 0", bus.fill_count); end
        push(32'hB1);
        checks++; if (bus.out_valid !== 1'b1 || bus.fill_count !== 2'd1) begin errors++; $display("FAIL len0_full: got valid=%b fill=%0d want valid=1 fill=1", bus.out_valid, bus.fill_count); end
        bus.out_ready = 1'b1;
        push(32'hB2);
        bus.out_ready = 1'b0;
        checks++; if (bus.evict_valid !== 1'b1 || bus.evict_data !== {32'h1B1, 32'hB1}) begin errors++; $display("FAIL len0_evict: got valid=%b data=%h want valid=1 data=%h", bus.evict_valid, bus.evict_data, {32'h1B1, 32'hB1}); end
        checks++; if (bus.fill_count !== 2'd1) begin errors++; $display("FAIL len0_slide_fill: got %0d want 1", bus.fill_count); end
        // Oversize cfg_length (7 on a DEPTH=5 chain) acts as 5.
        for (int i = 1; i <= 5; i++) begin
            bus5.in_valid = 1'b1;
            bus5.shift_in = DW'(i);
            @(posedge clock);
            #1;
            bus5.in_valid = 1'b0;
            if (i == 4) begin
                checks++; if (bus5.out_valid !== 1'b0 || bus5.fill_count !== 3'd4) begin errors++; $display("FAIL clamp_four: got valid=%b fill=%0d want valid=0 fill=4", bus5.out_valid, bus5.fill_count); end
            end
        end
        checks++; if (bus5.out_valid !== 1'b1 || bus5.fill_count !== 3'd5) begin errors++; $display("FAIL clamp_five: got valid=%b fill=%0d want valid=1 fill=5", bus5.out_valid, bus5.fill_count); end
    endtask

    task automatic test_reset_midstream();
        bus.cfg_length = 2'd3;
        idle(1);
        push(32'hC1);
        push(32'hC2);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.fill_count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ctrl: got fill=%0d valid=%b ready=%b want 0 0 1", bus.fill_count, bus.out_valid, bus.in_ready); end
        checks++; if (bus.data_out !== '0 || bus.evict_data !== '0 || bus.evict_valid !== 1'b0) begin errors++; $display("FAIL midrst_data: got data=%h evict=%h ev=%b want zeros", bus.data_out, bus.evict_data, bus.evict_valid); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);
        push(32'hD1);
        checks++; if (bus.fill_count !== 2'd1 || bus.evict_valid !== 1'b0) begin errors++; $display("FAIL midrst_push: got fill=%0d ev=%b want fill=1 ev=0", bus.fill_count, bus.evict_valid); end
        checks++; if (bus.data_out !== {32'h0, 32'h0, 32'h1D1, 32'h0, 32'h0, 32'hD1}) begin errors++; $display("FAIL midrst_window: got %h", bus.data_out); end
    endtask

`ifdef SHIFT_REG_FLUSH_EN
    task automatic test_flush();
        push(32'hE1);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.shift_in = {32'h1F1, 32'hF1};
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
        @(posedge clock);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.data_out !== '0 || bus.fill_count !== 2'd0 || bus.evict_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got data=%h fill=%0d ev=%b want zeros", bus.data_out, bus.fill_count, bus.evict_valid); end
    endtask
`endif

    // Safety net: the bench never waits on DUT events, but cap runtime anyway.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus.cfg_length  = 2'd3;
        bus.in_valid    = 1'b0;
        bus.shift_in    = '0;
        bus.out_ready   = 1'b0;
        bus5.cfg_length = 3'd7;
        bus5.in_valid   = 1'b0;
        bus5.shift_in   = '0;
        bus5.out_ready  = 1'b0;
`ifdef SHIFT_REG_FLUSH_EN
        bus.flush       = 1'b0;
        bus5.flush      = 1'b0;
`endif
        test_reset();
        test_fill();
        test_evict();
        test_len_change();
        test_len_clamp();
        test_reset_midstream();
`ifdef SHIFT_REG_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
